// File: rtl/rv_branch_predictor.sv
// rv_branch_predictor
//   Dynamic branch predictor for the fetch stage of the 5-stage RV32I pipeline.
//   It pairs a direct-mapped BTB (valid, tag, target, jump flag) with a table of
//   2-bit saturating direction counters.
//   - Fetch queries the predictor combinationally with F_pc.
//   - Execute trains it with resolved branch/JAL/JALR outcomes.
//   - After reset, a clear FSM walks the tables one entry per cycle. This keeps
//     the tables free of any reset network, so they can map onto RAM.
//
// Optional feature (macro RV_BP_GSHARE_EN):
//   When defined, a global history register is XORed into the counter index.
//   The BTB itself remains PC-indexed.
//   When undefined, no history register exists and pred_ghr is tied to 0.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   ready        tables initialised; predictions are valid
//   F_pc         fetch PC to predict
//   pred_taken   predict a redirect
//   pred_target  predicted next PC (0 on a miss or while clearing)
//   pred_ghr     history snapshot to carry with the instruction
//   upd_valid    training strobe from Execute
//   upd_pc       PC of the resolved control instruction
//   upd_is_jump  1 = JAL/JALR, 0 = conditional branch
//   upd_taken    resolved direction
//   upd_target   resolved target
//   upd_ghr      pred_ghr value carried back with the instruction
module rv_branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int GHR_BITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic [XLEN-1:0]     F_pc,
  output logic                pred_taken,
  output logic [XLEN-1:0]     pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [XLEN-1:0]     upd_pc,
  input  logic                upd_is_jump,
  input  logic                upd_taken,
  input  logic [XLEN-1:0]     upd_target,
  input  logic [GHR_BITS-1:0] upd_ghr
);

  localparam int IDX = $clog2(ENTRIES);

  typedef enum logic {StClear, StRun} state_e;

  state_e           state_q, state_d;
  logic [IDX-1:0]   clrCnt_q, clrCnt_d;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic                jump_q   [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [IDX-1:0]      fIdx, uIdx, fCtrIdx, uCtrIdx, fGhrExt, uGhrExt;
  logic [TAG_BITS-1:0] fTag, uTag;
  logic                fHit, uHit;
  logic [1:0]          fCtr, uCtr, uCtrNext;

  // Clear/run state and the clear walk counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StClear;
      clrCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    case (state_q)
      StClear: begin
        clrCnt_d = clrCnt_q + 1'b1;
        if (clrCnt_q == IDX'(ENTRIES - 1)) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  assign ready = (state_q == StRun);

`ifdef RV_BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [GHR_BITS:0]   ghrShift;

  // Only accepted conditional branches shift history; jumps carry no direction.
  always_comb begin
    ghrShift = {ghr_q, upd_taken};
    ghr_d    = ghr_q;
    if (upd_valid && !upd_is_jump && ready) ghr_d = ghrShift[GHR_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  always_comb begin
    fGhrExt                 = '0;
    fGhrExt[GHR_BITS-1:0]   = ghr_q;
    uGhrExt                 = '0;
    uGhrExt[GHR_BITS-1:0]   = upd_ghr;
  end

  assign pred_ghr = ghr_q;

  logic unused_bits;
  assign unused_bits = ^{F_pc[1:0], F_pc[XLEN-1:IDX+TAG_BITS+2],
                         upd_pc[1:0], upd_pc[XLEN-1:IDX+TAG_BITS+2]};
`else
  assign fGhrExt  = '0;
  assign uGhrExt  = '0;
  assign pred_ghr = '0;

  logic unused_bits;
  assign unused_bits = ^{F_pc[1:0], F_pc[XLEN-1:IDX+TAG_BITS+2],
                         upd_pc[1:0], upd_pc[XLEN-1:IDX+TAG_BITS+2], upd_ghr};
`endif

  assign fIdx    = F_pc[IDX+1:2];
  assign fTag    = F_pc[IDX+1+TAG_BITS:IDX+2];
  assign uIdx    = upd_pc[IDX+1:2];
  assign uTag    = upd_pc[IDX+1+TAG_BITS:IDX+2];
  assign fCtrIdx = fIdx ^ fGhrExt;
  assign uCtrIdx = uIdx ^ uGhrExt;

  // Gating with ready ensures the never-reset table contents
  // cannot leak out before the clear walk completes.
  always_comb begin
    fHit        = valid_q[fIdx] && (tag_q[fIdx] == fTag);
    fCtr        = ctr_q[fCtrIdx];
    pred_taken  = 1'b0;
    pred_target = '0;
    if (ready && fHit) begin
      pred_taken  = jump_q[fIdx] | fCtr[1];
      pred_target = target_q[fIdx];
    end
  end

  // Saturating counter step. Jumps are always taken, so they pin the counter high.
  always_comb begin
    uHit     = valid_q[uIdx] && (tag_q[uIdx] == uTag);
    uCtr     = ctr_q[uCtrIdx];
    uCtrNext = uCtr;
    if (upd_is_jump || jump_q[uIdx])       uCtrNext = 2'b11;
    else if (upd_taken && uCtr != 2'b11)   uCtrNext = uCtr + 2'b01;
    else if (!upd_taken && uCtr != 2'b00)  uCtrNext = uCtr - 2'b01;
  end

  // Table write port.
  // Each table takes a single write per cycle:
  //   - the clear walk while clearing;
  //   - otherwise the training update.
  // Reads see pre-write contents, so there is no same-cycle bypass.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StClear) begin
        valid_q[clrCnt_q] <= 1'b0;
        ctr_q[clrCnt_q]   <= 2'b01;
      end else if (upd_valid) begin
        if (uHit) begin
          ctr_q[uCtrIdx] <= uCtrNext;
          if (upd_taken) begin
            target_q[uIdx] <= upd_target;
            jump_q[uIdx]   <= upd_is_jump;
          end
        end else if (upd_taken) begin
          valid_q[uIdx]  <= 1'b1;
          tag_q[uIdx]    <= uTag;
          target_q[uIdx] <= upd_target;
          jump_q[uIdx]   <= upd_is_jump;
          ctr_q[uCtrIdx] <= upd_is_jump ? 2'b11 : 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_branch_predictor.sv
// tb_rv_branch_predictor
//   Directed bench for rv_branch_predictor in its default configuration:
//   64 entries, 8 tag bits, history disabled.
//   Expected results are queued when a query is driven and popped when the
//   outputs are compared.
module tb_rv_branch_predictor;

  logic        clk;
  logic        reset;
  logic        ready;
  logic [31:0] F_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [5:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [5:0]  upd_ghr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        ready;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t expQ[$];

  rv_branch_predictor dut (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .F_pc       (F_pc),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .pred_ghr   (pred_ghr),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_is_jump(upd_is_jump),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .upd_ghr    (upd_ghr)
  );

  // Free-running clock; the DUT works on the rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = expQ.pop_front();
    total++;
    assert (ready === e.ready) else begin
      bad++;
      $error("[TB] FAIL %s.ready observed=%0b expected=%0b", e.name, ready, e.ready);
    end
    total++;
    assert (pred_taken === e.taken) else begin
      bad++;
      $error("[TB] FAIL %s.taken observed=%0b expected=%0b", e.name, pred_taken, e.taken);
    end
    total++;
    assert (pred_target === e.target) else begin
      bad++;
      $error("[TB] FAIL %s.target observed=%h expected=%h", e.name, pred_target, e.target);
    end
  endtask

  // Drive a fetch query, queue its expectation, and check it after settling.
  task automatic predict(input string nm, input logic [31:0] pc, input logic expReady,
                         input logic expTaken, input logic [31:0] expTarget);
    exp_t e;
    F_pc     = pc;
    e.name   = nm;
    e.ready  = expReady;
    e.taken  = expTaken;
    e.target = expTarget;
    expQ.push_back(e);
    #1;
    checkOutput();
  endtask

  // Present one training update. The caller advances the clock with stepClock.
  task automatic applyStimulus(input logic [31:0] pc, input logic isJump,
                               input logic taken, input logic [31:0] target);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_is_jump = isJump;
    upd_taken   = taken;
    upd_target  = target;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic isJump,
                       input logic taken, input logic [31:0] target);
    applyStimulus(pc, isJump, taken, target);
    stepClock();
  endtask

  initial begin
    logic [31:0] clrPcs [3];
    clrPcs[0] = 32'h0;
    clrPcs[1] = 32'h100;
    clrPcs[2] = 32'hFFFC;

    reset       = 1'b1;
    F_pc        = '0;
    upd_valid   = 1'b0;
    upd_pc      = '0;
    upd_is_jump = 1'b0;
    upd_taken   = 1'b0;
    upd_target  = '0;
    upd_ghr     = '0;

    // Reset for one cycle, then the clear walk takes exactly 64 cycles.
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      predict("clear", clrPcs[i % 3], 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
    end
    predict("ready_up", 32'h0, 1'b1, 1'b0, 32'h0);
    total++;
    assert (pred_ghr === 6'd0) else begin
      bad++;
      $error("[TB] FAIL ghr_zero observed=%h expected=%h", pred_ghr, 6'd0);
    end

    // First allocation of a taken branch.
    train(32'h100, 1'b0, 1'b1, 32'h40);
    predict("alloc_hit", 32'h100, 1'b1, 1'b1, 32'h40);
    predict("alloc_neighbor", 32'h104, 1'b1, 1'b0, 32'h0);

    // Hysteresis: 10 -> 01 -> 00 -> 01 -> 10 -> 11 (saturate) -> 10.
    train(32'h100, 1'b0, 1'b0, 32'h0);
    train(32'h100, 1'b0, 1'b0, 32'h0);
    predict("ctr00", 32'h100, 1'b1, 1'b0, 32'h40);
    train(32'h100, 1'b0, 1'b1, 32'h40);
    predict("ctr01", 32'h100, 1'b1, 1'b0, 32'h40);
    train(32'h100, 1'b0, 1'b1, 32'h40);
    predict("ctr10", 32'h100, 1'b1, 1'b1, 32'h40);
    for (int i = 0; i < 3; i++) train(32'h100, 1'b0, 1'b1, 32'h40);
    train(32'h100, 1'b0, 1'b0, 32'h0);
    predict("ctr11_nt", 32'h100, 1'b1, 1'b1, 32'h40);

    // Aliasing: 0x1100 shares index 0 with 0x100 but has a different tag.
    predict("alias_miss", 32'h1100, 1'b1, 1'b0, 32'h0);
    train(32'h1100, 1'b1, 1'b1, 32'h2000);
    predict("alias_jump", 32'h1100, 1'b1, 1'b1, 32'h2000);
    predict("alias_evict", 32'h100, 1'b1, 1'b0, 32'h0);

    // A not-taken miss must not allocate or disturb the occupant.
    train(32'h200, 1'b0, 1'b0, 32'h999);
    predict("nt_miss", 32'h200, 1'b1, 1'b0, 32'h0);
    predict("nt_keep", 32'h1100, 1'b1, 1'b1, 32'h2000);

    // Top index boundary and a second populated entry.
    train(32'hFFFC, 1'b0, 1'b1, 32'h10);
    predict("top_idx", 32'hFFFC, 1'b1, 1'b1, 32'h10);
    train(32'h1104, 1'b1, 1'b1, 32'h3000);
    predict("idx1_jump", 32'h1104, 1'b1, 1'b1, 32'h3000);

    // Same-cycle update and predict: old contents now, new contents next cycle.
    train(32'h100, 1'b0, 1'b1, 32'h40);
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0);
    predict("same_cycle_old", 32'h100, 1'b1, 1'b1, 32'h40);
    stepClock();
    predict("same_cycle_new", 32'h100, 1'b1, 1'b0, 32'h40);

    // Reset mid-run; updates presented during the clear walk must be ignored.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(32'h1100, 1'b1, 1'b1, 32'h2000);
      predict("reclear", clrPcs[i % 3], 1'b0, 1'b0, 32'h0);
      if (i == 63) upd_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    upd_valid = 1'b0;
    predict("post_clear_1100", 32'h1100, 1'b1, 1'b0, 32'h0);
    predict("post_clear_top", 32'hFFFC, 1'b1, 1'b0, 32'h0);
    predict("post_clear_1104", 32'h1104, 1'b1, 1'b0, 32'h0);

    total++;
    assert (expQ.size() == 0) else begin
      bad++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
